// File: rtl/fifo_fwft_flags_if.sv
// Handshake bundle for fifo_fwft_flags.
// Groups the write side (wr_en, din), the read side (rd_en, dout), flush
// and every status flag, so a producer/consumer can pass the whole FIFO
// connection around as one object.
//   master : the user of the FIFO; drives requests and observes flags
//   slave  : the FIFO side; receives requests and drives data and flags
interface fifo_fwft_flags_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input logic clk
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    input  clk,
    output flush, wr_en, din, rd_en,
    input  full, almost_full, dout, empty, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  clk,
    input  flush, wr_en, din, rd_en,
    output full, almost_full, dout, empty, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_fwft_flags_sdp_ram.sv
// Simple dual-port storage for fifo_fwft_flags.
// One synchronous write port and one asynchronous (combinational) read
// port. Kept in its own module so it can later be replaced by a block-RAM
// wrapper. The array is deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module sdp_ram #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_fwft_flags.sv
// First-word-fall-through FIFO with occupancy flags.
// The head entry is visible on dout whenever empty=0; an accepted read
// moves to the next entry with no bubble. Head/tail pointers carry one
// extra bit so all DEPTH entries are usable and full/empty are unambiguous.
// All status outputs come from the registered pointers only.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous clear of contents and sticky errors
//   wr_en, din        : write request and data (dropped when full)
//   rd_en, dout       : read acknowledge and head data (ignored when empty)
//   full, empty       : occupancy == DEPTH / == 0
//   almost_full       : occupancy >= AF_LEVEL
//   almost_empty      : occupancy <= AE_LEVEL
//   count             : occupancy
//   overflow          : sticky, write attempted while full
//   underflow         : sticky, read attempted while empty
module fifo_fwft_flags #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] AF_L = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_L = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             wr_accept;
  logic             rd_accept;

  // Pointer difference is exact modulo 2*DEPTH, which is the occupancy.
  assign count        = tail_reg - head_reg;
  assign empty        = (tail_reg == head_reg);
  assign full         = (tail_reg[AW] != head_reg[AW]) &&
                        (tail_reg[AW-1:0] == head_reg[AW-1:0]);
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  assign wr_accept = wr_en && !full && !flush;
  assign rd_accept = rd_en && !empty && !flush;

  always_comb begin
    head_next      = head_reg;
    tail_next      = tail_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (flush) begin
      head_next      = '0;
      tail_next      = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (wr_accept) tail_next = tail_reg + 1'b1;
      if (rd_accept) head_next = head_reg + 1'b1;
      if (wr_en && full) overflow_next = 1'b1;
      if (rd_en && empty) underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Asynchronous read at the head gives the fall-through behaviour: a word
  // written into an empty FIFO is on dout as soon as the tail moves past it.
  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (tail_reg[AW-1:0]),
    .wdata (din),
    .raddr (head_reg[AW-1:0]),
    .rdata (dout)
  );
endmodule

// File: doc/fifo_fwft_flags.md
FIFO_FWFT_FLAGS -- requirements
Module: fifo_fwft_flags

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 16: number of storage entries, power of 2, >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when occupancy >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when occupancy <= AE_LEVEL.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port flush, input, 1: synchronous clear of contents.
REQ-008 SHALL have port wr_en, input, 1: write request.
REQ-009 SHALL have port din, input, WIDTH: write data.
REQ-010 SHALL have port full, output, 1: occupancy == DEPTH.
REQ-011 SHALL have port almost_full, output, 1: occupancy >= AF_LEVEL.
REQ-012 SHALL have port rd_en, input, 1: read acknowledge.
REQ-013 SHALL have port dout, output, WIDTH: head entry, valid whenever empty=0 (first-word fall-through).
REQ-014 SHALL have port empty, output, 1: occupancy == 0.
REQ-015 SHALL have port almost_empty, output, 1: occupancy <= AE_LEVEL.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.
REQ-017 SHALL have port overflow, output, 1: sticky; set by wr_en while full.
REQ-018 SHALL have port underflow, output, 1: sticky; set by rd_en while empty.

Function
REQ-019 SHALL use all DEPTH entries; head/tail pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = (MSBs differ, lower bits equal).
REQ-020 SHALL accept a write iff wr_en=1 and full=0; din is stored at the tail and the tail advances by 1.
REQ-021 SHALL accept a read iff rd_en=1 and empty=0; the head advances by 1.
REQ-022 SHALL, on a write to an empty FIFO, present that word on dout with empty=0 in the next cycle (1-cycle write-to-read latency).
REQ-023 SHALL, after an accepted read, present the next entry on dout in the next cycle, with no bubble.
REQ-024 SHALL, on simultaneous accepted write and read, leave count unchanged and advance both pointers.
REQ-025 SHALL ignore wr_en when full, even with a concurrent rd_en; the write is dropped, overflow is set, and the read proceeds.
REQ-026 SHALL ignore rd_en when empty, even with a concurrent wr_en; underflow is set, and the write proceeds.
REQ-027 SHALL derive count, full, empty, almost_full and almost_empty combinationally from registered pointers only; they do not depend on same-cycle wr_en or rd_en.
REQ-028 SHALL, on flush=1, set pointers to 0 and clear overflow and underflow at the next edge; flush overrides wr_en and rd_en in that cycle.
REQ-029 SHALL keep dout stable while empty=1 and no read is accepted; its value while empty is don't-care.
REQ-030 SHALL make overflow and underflow hold until flush or reset.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force head=0 and tail=0, giving count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), overflow=0, underflow=0.
REQ-032 SHALL not reset the storage array.
REQ-033 SHALL, after reset deasserts mid-traffic, discard all prior contents; the first accepted write after release is the first word read.

Structure
REQ-034 SHALL need no shared package; the pointer width localparam is local to the module.
REQ-035 SHALL place storage in one sub-module sdp_ram (WIDTH, DEPTH; one write port, one asynchronous read port) to allow later swapping to a block RAM.
REQ-036 SHALL be a drop-in superset of the existing fifo_fwft port set, except for the reset polarity.

Verification
REQ-037 SHALL verify: DEPTH=4, write 1,2,3,4 -> full=1 after the 4th, count=4, then reads return 1,2,3,4, empty=1.
REQ-038 SHALL verify: write 0xA to empty -> next cycle empty=0, dout=0xA; rd_en -> next cycle empty=1.
REQ-039 SHALL verify: full, with wr_en=1 and rd_en=1, din=9 -> one word read, 9 dropped, count=3, overflow=1.
REQ-040 SHALL verify: empty, with rd_en=1 -> underflow=1, count=0; then flush -> underflow=0.
REQ-041 SHALL verify: DEPTH=8, 20 cycles of simultaneous write/read at count=3 -> count stays 3, data in order across pointer wrap.
REQ-042 SHALL verify: rst_n pulsed low between edges at count=5 -> immediately count=0, empty=1, flags clear.
